// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared MIPS writeback control definitions
package regfile_write_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wb_state_t;

    // Requester indices, also the encoding of the round-robin pointer
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-port register-file write arbiter with power-up clear sweep
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done,
    output logic [15:0]           conflict_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    wb_state_t             state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  rr_ptr;
    logic                  run_active;
    logic                  both_valid;

    assign run_active = (state == ST_RUN) && !RST;
    assign both_valid = req0_valid && req1_valid;

    // The pointer only matters when both ask; a lone requester always wins
    assign req0_ready = run_active && req0_valid && (!req1_valid || rr_ptr == REQ_ALU);
    assign req1_ready = run_active && req1_valid && (!req0_valid || rr_ptr == REQ_LOAD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_INIT;
            sweep_cnt    <= '0;
            rr_ptr       <= REQ_LOAD;
            conflict_cnt <= '0;
            init_done    <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    rf_we     <= 1'b1;
                    rf_waddr  <= sweep_cnt;
                    rf_wdata  <= '0;
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Writes to register 0 are accepted but never reach the file
                    if (req0_ready) begin
                        rf_we    <= (req0_addr != '0);
                        rf_waddr <= req0_addr;
                        rf_wdata <= req0_data;
                    end else if (req1_ready) begin
                        rf_we    <= (req1_addr != '0);
                        rf_waddr <= req1_addr;
                        rf_wdata <= req1_data;
                    end else begin
                        rf_we <= 1'b0;
                    end
                    if (both_valid) begin
                        rr_ptr       <= ~rr_ptr;
                        conflict_cnt <= sat_inc16(conflict_cnt);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    wr_t  sb[$];
    logic mon_en = 1'b0;
    logic m_ptr = 1'b1;
    int   m_conf = 0;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: independent arbitration model predicts each cycle's write for the next cycle
    always @(negedge CLK) begin
        if (mon_en) begin
            wr_t  e;
            logic g0;
            logic g1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (rf_we !== e.we || (e.we && (rf_waddr !== e.addr || rf_wdata !== e.data))) begin
                    errors++;
                    $display("FAIL sb_write got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                             rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
                end
            end
            checks++;
            if (conflict_cnt !== 16'(m_conf)) begin
                errors++;
                $display("FAIL sb_conflict got %0d want %0d", conflict_cnt, m_conf);
            end
            g0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
            g1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
            checks++;
            if (req0_ready !== g0 || req1_ready !== g1) begin
                errors++;
                $display("FAIL sb_ready got %b%b want %b%b", req0_ready, req1_ready, g0, g1);
            end
            if (req0_valid && req1_valid) begin
                m_ptr = !m_ptr;
                m_conf++;
            end
            if (g0)      e = '{we: (req0_addr != 5'd0), addr: req0_addr, data: req0_data};
            else if (g1) e = '{we: (req1_addr != 5'd0), addr: req1_addr, data: req1_data};
            else         e = '{we: 1'b0, addr: 5'd0, data: 32'd0};
            sb.push_back(e);
        end
    end

    task automatic test_reset();
        logic       exp_we;
        logic [4:0] exp_addr;
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h7;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h8;
        for (int k = 0; k <= 32; k++) begin
            @(negedge CLK);
            exp_we   = (k != 0);
            exp_addr = (k == 0) ? 5'd0 : 5'(k - 1);
            checks++;
            if (rf_we !== exp_we || (exp_we && (rf_waddr !== exp_addr || rf_wdata !== 32'd0))) begin
                errors++;
                $display("FAIL reset_sweep cycle %0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=0",
                         k, rf_we, rf_waddr, rf_wdata, exp_we, exp_addr);
            end
            checks++;
            if (init_done !== (k == 32)) begin
                errors++;
                $display("FAIL reset_init_done cycle %0d got %b want %b", k, init_done, (k == 32));
            end
            if (k < 32) begin
                checks++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_ready cycle %0d got %b%b want 00", k, req0_ready, req1_ready);
                end
            end
            if (k == 19) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (k < 32) begin
                @(posedge CLK);
                #1;
            end
        end
        checks++;
        if (conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_conflict got %0d want 0", conflict_cnt);
        end
        @(posedge CLK);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        @(posedge CLK);
        #1;
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h1234;
        @(negedge CLK);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready);
        end
        @(posedge CLK);
        #1;
        req0_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL single_write got we=%b addr=%0d data=%h want we=1 addr=8 data=1234",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_contention();
        logic exp_g1;
        @(posedge CLK);
        #1;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h200;
        for (int i = 0; i < 4; i++) begin
            exp_g1 = (i % 2 == 0);
            @(negedge CLK);
            checks++;
            if (req1_ready !== exp_g1 || req0_ready !== !exp_g1) begin
                errors++;
                $display("FAIL contention_grant %0d got %b%b want %b%b", i, req0_ready, req1_ready, !exp_g1, exp_g1);
            end
            @(posedge CLK);
            #1;
            if (exp_g1) begin
                req1_addr = 5'(12 + i); req1_data = 32'h200 + 32'(i) + 32'd1;
            end else begin
                req0_addr = 5'(20 + i); req0_data = 32'h100 + 32'(i) + 32'd1;
            end
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(negedge CLK);
        checks++;
        if (conflict_cnt !== 16'd4) begin
            errors++;
            $display("FAIL contention_count got %0d want 4", conflict_cnt);
        end
    endtask

    task automatic test_zero_addr();
        @(posedge CLK);
        #1;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF;
        @(negedge CLK);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready got %b want 1", req1_ready);
        end
        @(posedge CLK);
        #1;
        req1_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_we got %b want 0", rf_we);
        end
    endtask

    task automatic test_same_addr();
        @(posedge CLK);
        #1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hB;
        @(negedge CLK);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL same_first_grant got %b%b want 01", req0_ready, req1_ready);
        end
        @(posedge CLK);
        #1;
        req1_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (req0_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hB) begin
            errors++;
            $display("FAIL same_first_write got rdy0=%b we=%b addr=%0d data=%h want rdy0=1 we=1 addr=9 data=b",
                     req0_ready, rf_we, rf_waddr, rf_wdata);
        end
        @(posedge CLK);
        #1;
        req0_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA || conflict_cnt !== 16'd5) begin
            errors++;
            $display("FAIL same_second_write got we=%b addr=%0d data=%h cnt=%0d want we=1 addr=9 data=a cnt=5",
                     rf_we, rf_waddr, rf_wdata, conflict_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        @(posedge CLK);
        #1;
        mon_en = 1'b0;
        sb.delete();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h55;
        @(negedge CLK);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_hs got %b want 1", req0_ready);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        req0_addr = 5'd6; req0_data = 32'h66;
        @(negedge CLK);
        checks++;
        if (req0_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
            errors++;
            $display("FAIL midrst_during got rdy0=%b we=%b addr=%0d want rdy0=0 we=1 addr=5",
                     req0_ready, rf_we, rf_waddr);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        req0_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (rf_we !== 1'b0 || init_done !== 1'b0 || conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_after got we=%b init=%b cnt=%0d want we=0 init=0 cnt=0",
                     rf_we, init_done, conflict_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'd0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_sweep %0d got we=%b addr=%0d data=%h init=%b want we=1 addr=%0d data=0 init=0",
                         k, rf_we, rf_waddr, rf_wdata, init_done, k);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_addr();
        test_same_addr();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register address width (2**ADDR_WIDTH registers).
REQ-003 SHALL have one clock and a reset that is synchronous and active-high: CLK and RST.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 req0_valid  input  1  ALU writeback request.
REQ-007 req0_addr  input  ADDR_WIDTH  ALU destination register.
REQ-008 req0_data  input  DATA_WIDTH  ALU result.
REQ-009 req0_ready  output  1  ALU request accepted this cycle.
REQ-010 req1_valid, req1_addr, req1_data, req1_ready SHALL mirror REQ-006..009 for load writeback.
REQ-011 rf_we  output  1  register-file write enable (drives RegWrite).
REQ-012 rf_waddr  output  ADDR_WIDTH  register-file write address.
REQ-013 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-014 init_done  output  1  clear sweep finished; arbitration active.
REQ-015 conflict_cnt  output  16  saturating count of cycles where both requests were valid.

Function
REQ-016 FSM SHALL have two states: INIT (clear sweep) and RUN.
REQ-017 In INIT, rf_we=1, rf_waddr=sweep counter, rf_wdata=0; counter advances 0..2**ADDR_WIDTH-1, one register per cycle.
REQ-018 INIT->RUN SHALL occur on the cycle after the last address is written; init_done=1 from that cycle onward.
REQ-019 In INIT both ready outputs SHALL be 0.
REQ-020 In RUN, a handshake completes when reqN_valid & reqN_ready; ready SHALL be combinational from valid and the arbitration pointer.
REQ-021 At most one ready SHALL be high per cycle; ready SHALL never be high without its valid.
REQ-022 Single valid requester SHALL be granted immediately.
REQ-023 Both valid: grant goes to the requester indicated by a round-robin pointer; pointer flips to the other requester after each contended grant; pointer reset value selects req1 (load).
REQ-024 Non-granted requester SHALL hold valid/addr/data stable until granted.
REQ-025 Accepted write SHALL appear on rf_we/rf_waddr/rf_wdata exactly one cycle after the handshake (registered outputs); rf_we=0 in RUN cycles with no prior handshake.
REQ-026 Handshake with addr==0 SHALL complete but produce rf_we=0 ($zero write dropped).
REQ-027 Both requesters targeting the same address SHALL be serialised in grant order; the later grant's data is final.
REQ-028 conflict_cnt SHALL increment by 1 on each RUN cycle with both valids high, saturating at 16'hFFFF.

Reset
REQ-029 RST SHALL force: state=INIT, sweep counter=0, pointer=req1, conflict_cnt=0, init_done=0, ready outputs=0.
REQ-030 rf_we, rf_waddr, rf_wdata registers SHALL reset to 0, discarding any pending accepted write.
REQ-031 RST asserted mid-INIT or mid-RUN SHALL restart the full clear sweep from address 0 on the cycle after RST deasserts.

Structure
REQ-032 State encoding (INIT, RUN) and requester index constants SHALL live in a shared package with the other MIPS control definitions.
REQ-033 Block SHALL be a single module with no sub-modules; one instance sits in front of the register file write port.

Verification
REQ-034 Reset, no requests -> rf_we=1 for 32 cycles, addresses 0..31, data 0; init_done rises on cycle 32; readies 0 throughout.
REQ-035 RUN, req0 only {addr 8, data 0x1234} -> req0_ready=1 same cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234.
REQ-036 RUN, both valid for 4 cycles with fresh data each grant -> grants req1,req0,req1,req0; conflict_cnt=4.
REQ-037 RUN, req1 {addr 0, data 0xFFFF} -> req1_ready=1; next cycle rf_we=0.
REQ-038 Both valid to addr 9 (req0 0xA, req1 0xB) -> rf writes 0xB then 0xA in consecutive cycles.
REQ-039 RST pulsed during RUN with a pending accepted write -> rf_we=0 next cycle, init_done=0, sweep restarts at address 0.
